// File: rtl/lshift_seq.sv
// lshift_seq: iterative 32-bit logical left shifter.
// One binary-weighted stage (1, 2, 4, 8, 16 bits) is applied per clock.
// A valid/ready handshake is used on both the operand and result sides.
module lshift_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [4:0]  s,
  output logic        in_ready,
  output logic [31:0] out,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] acc;
  logic [4:0]  amt;
  logic [2:0]  stage;
  logic        accept;
  logic [4:0]  stage_bit;
  logic [31:0] acc_shifted;

  // Stage weight doubles as both the amt bit select and the shift distance.
  always_comb begin
    stage_bit   = 5'd1 << stage;
    acc_shifted = acc;
    if ((amt & stage_bit) != '0) begin
      acc_shifted = acc << stage_bit;
    end
  end

  // Operands are taken whenever the block reports ready and start is high.
  always_comb begin
    accept = in_ready && start;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: capture on acceptance, otherwise step one stage while shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      amt   <= '0;
      stage <= '0;
    end else if (accept) begin
      acc   <= a;
      amt   <= s;
      stage <= '0;
    end else if (state == SHIFT) begin
      acc   <= acc_shifted;
      stage <= stage + 3'd1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (stage == 3'd4) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = start ? SHIFT : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs depend only on state and out_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE:    in_ready = 1'b1;
      SHIFT:   in_ready = 1'b0;
      DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  assign out = acc;

endmodule

// File: tb/tb_lshift_seq.sv
// Self-checking bench for lshift_seq: directed test-plan steps plus
// randomized operations checked against a plain a << s reference.
module tb_lshift_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [4:0]  s;
  logic        in_ready;
  logic [31:0] out;
  logic        out_valid;
  logic        out_ready;

  int n_checks;
  int n_fail;

  lshift_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .s         (s),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for out_valid after an acceptance edge; returns edges taken.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // One complete operation: accept, check latency/result, optional stall, transfer.
  task automatic do_op(input logic [31:0] av, input logic [4:0] sv,
                       input logic [31:0] exp, input int stall);
    int lat;
    @(negedge clk);
    a         = av;
    s         = sv;
    start     = 1'b1;
    out_ready = 1'b1;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    start     = 1'b0;
    a         = $urandom;
    s         = 5'($urandom);
    out_ready = (stall == 0);
    chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
    wait_valid(lat);
    chk("latency", lat, 5);
    chk("result", out, exp);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_out", out, exp);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("done_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("after_xfer_valid", {31'd0, out_valid}, 32'd0);
    chk("after_xfer_idle", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] pa [0:2];
    logic [4:0]  ps [0:2];
    logic [31:0] ra;
    logic [4:0]  rs;
    int lat;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    a         = '0;
    s         = '0;
    out_ready = 1'b0;

    // Reset state.
    #12;
    chk("reset_out", out, 32'h0);
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Boundary shift amounts and test-plan values.
    do_op(32'h00000001, 5'd31, 32'h80000000, 0);
    do_op(32'hFFFFFFFF, 5'd0,  32'hFFFFFFFF, 0);
    do_op(32'hFFFFFFFF, 5'd4,  32'hFFFFFFF0, 0);
    do_op(32'h12345678, 5'd16, 32'h56780000, 0);

    // Backpressure: result held stable for 10 cycles, then one transfer.
    do_op(32'hDEADBEEF, 5'd13, 32'hB7DDE000, 10);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("no_dup_valid", {31'd0, out_valid}, 32'd0);
    end

    // Back-to-back with start held high: one result every 6 cycles.
    pa[0] = 32'h1; ps[0] = 5'd1;
    pa[1] = 32'h3; ps[1] = 5'd2;
    pa[2] = 32'hF; ps[2] = 5'd31;
    @(negedge clk);
    a = pa[0];
    s = ps[0];
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin
        a = pa[i + 1];
        s = ps[i + 1];
      end else begin
        start = 1'b0;
        a = $urandom;
      end
      wait_valid(lat);
      chk("b2b_latency", lat + 1, 6);
      chk("b2b_result", out, pa[i] << ps[i]);
      @(posedge clk);
      #1;
      chk("b2b_xfer_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("b2b_end_idle", {31'd0, in_ready}, 32'd1);

    // start during SHIFT stage 2 must be ignored.
    @(negedge clk);
    a = 32'h1;
    s = 5'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a = 32'hAAAAAAAA;
    s = 5'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_valid(lat);
    chk("ignore_latency", lat + 3, 5);
    chk("ignore_result", out, 32'h20);
    @(posedge clk);
    #1;
    repeat (8) begin
      chk("ignore_no_extra", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset during SHIFT stage 3 aborts the operation.
    @(negedge clk);
    a = 32'hCAFEF00D;
    s = 5'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out", out, 32'h0);
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'h5, 5'd1, 32'hA, 0);

    // Randomized operations against the a << s reference.
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rs = 5'($urandom_range(31, 0));
      do_op(ra, rs, ra << rs, int'($urandom_range(3, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
